scoreboard_hazard_unit: RTL

//  Parametrised successor hazard unit for deeper RV32 pipelines with multi-cycle and variable-latency functional units.
//  - Keeps a per-register pending-write scoreboard with latency countdowns, replacing the single-stage rd match.
//  - Gates issue on RAW/WAW hazards.
//  - Sequences fence drain and interrupt acceptance through an FSM.
//  - Sits between decode/issue and the execute units; drives stall/flush toward the front end.

---
 rtl/hazard_sb_pkg.sv | 23 ++
 rtl/scoreboard_hazard_unit_if.sv | 47 ++++
 rtl/hazard_sb_entry.sv | 62 ++++++
 rtl/scoreboard_hazard_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/hazard_sb_pkg.sv
// Shared types for the scoreboard hazard unit: FSM states, the per-register
// scoreboard entry and default parameters.
package hazard_sb_pkg;

  localparam int MAX_LAT_DEFAULT = 8;

  // Entries hold a fixed-width countdown wide enough for any MAX_LAT up to 255.
  localparam int SB_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN,
    DRAIN_F,
    DRAIN_I,
    ACK_F
  } sb_state_t;

  typedef struct packed {
    logic                pend;
    logic                is_var;
    logic [SB_CNT_W-1:0] cnt;
  } sb_entry_t;

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// Issue/writeback/control bundle between the front end and the scoreboard hazard unit.
interface scoreboard_hazard_unit_if
  import hazard_sb_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int MAX_LAT = MAX_LAT_DEFAULT
);
  localparam int RW    = $clog2(NREGS);
  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic             issue_valid;
  logic             issue_ready;
  logic [RW-1:0]    issue_rs1;
  logic [RW-1:0]    issue_rs2;
  logic             issue_rs1_used;
  logic             issue_rs2_used;
  logic [RW-1:0]    issue_rd;
  logic             issue_wen;
  logic [LAT_W-1:0] issue_lat;
  logic             wb_valid;
  logic [RW-1:0]    wb_rd;
  logic             kill_valid;
  logic [RW-1:0]    kill_rd;
  logic             redirect;
  logic             fence_req;
  logic             fence_ack;
  logic             intr_req;
  logic             intr_ack;
  logic             flush_front;
  logic             stall_front;
  logic             busy;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_wen, issue_lat, wb_valid, wb_rd, kill_valid, kill_rd,
           redirect, fence_req, intr_req,
    input  issue_ready, fence_ack, intr_ack, flush_front, stall_front, busy
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_wen, issue_lat, wb_valid, wb_rd, kill_valid, kill_rd,
           redirect, fence_req, intr_req,
    output issue_ready, fence_ack, intr_ack, flush_front, stall_front, busy
  );

endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: pending-write tracking for a single architectural register,
// either as a fixed-latency countdown or as a variable-latency wait for writeback.
module hazard_sb_entry
  import hazard_sb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_i,
  input  logic                set_var_i,
  input  logic [SB_CNT_W-1:0] set_cnt_i,
  input  logic                wb_hit_i,
  input  logic                kill_hit_i,
  output logic                pend_o,
  output logic                var_o,
  output logic                clr_now_o
);

  sb_entry_t entry_q;
  sb_entry_t entry_d;
  logic      clr_now;

  // A pending write retires this cycle on a kill, on its writeback, or on the last countdown tick.
  always_comb begin
    clr_now = 1'b0;
    if (entry_q.pend) begin
      if (kill_hit_i) begin
        clr_now = 1'b1;
      end else if (entry_q.is_var) begin
        clr_now = wb_hit_i;
      end else begin
        clr_now = (entry_q.cnt == SB_CNT_W'(1));
      end
    end
  end

  // A new issue to this register overrides any clear happening in the same cycle.
  always_comb begin
    entry_d = entry_q;
    if (set_i) begin
      entry_d.pend   = 1'b1;
      entry_d.is_var = set_var_i;
      entry_d.cnt    = set_var_i ? '0 : set_cnt_i;
    end else if (clr_now) begin
      entry_d = '0;
    end else if (entry_q.pend && !entry_q.is_var) begin
      entry_d.cnt = entry_q.cnt - SB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign pend_o    = entry_q.pend;
  assign var_o     = entry_q.is_var;
  assign clr_now_o = clr_now;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard-based issue hazard unit with fence drain and interrupt sequencing.
// Define HAZARD_WB_BYPASS_EN to let same-cycle clears release dependents immediately.
module scoreboard_hazard_unit
  import hazard_sb_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int MAX_LAT = MAX_LAT_DEFAULT
) (
  input logic                     CLK,
  input logic                     RST,
  scoreboard_hazard_unit_if.slave bus
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);

`ifdef HAZARD_WB_BYPASS_EN
  localparam logic WB_BYPASS = 1'b1;
`else
  localparam logic WB_BYPASS = 1'b0;
`endif

  logic [NREGS-1:0]    rs1_oh;
  logic [NREGS-1:0]    rs2_oh;
  logic [NREGS-1:0]    rd_oh;
  logic [NREGS-1:0]    wb_oh;
  logic [NREGS-1:0]    kill_oh;
  logic [NREGS-1:0]    set_vec;
  logic [NREGS-1:0]    pend_vec;
  logic [NREGS-1:0]    var_vec;
  logic [NREGS-1:0]    clr_vec;
  logic [NREGS-1:0]    hz_pend;
  logic [SB_CNT_W-1:0] lat_ext;
  logic                lat_is_var;
  logic                wen_nz;
  logic                raw;
  logic                waw;
  logic                fire;
  logic                busy_w;
  logic                var_busy;
  logic                issue_ready_w;
  logic                intr_ack_w;
  sb_state_t           state_q;
  logic                fence_ack_q;

  assign rs1_oh  = NREGS'(1) << bus.issue_rs1;
  assign rs2_oh  = NREGS'(1) << bus.issue_rs2;
  assign rd_oh   = NREGS'(1) << bus.issue_rd;
  assign wb_oh   = NREGS'(1) << bus.wb_rd;
  assign kill_oh = NREGS'(1) << bus.kill_rd;

  // x0 is never tracked, so a write to it neither sets an entry nor causes WAW.
  assign wen_nz     = bus.issue_wen & (bus.issue_rd != '0);
  assign lat_is_var = (bus.issue_lat == '0);
  assign lat_ext    = SB_CNT_W'(bus.issue_lat);
  assign set_vec    = {NREGS{fire & wen_nz}} & rd_oh;

  for (genvar i = 0; i < NREGS; i++) begin : g_entry
    hazard_sb_entry u_entry (
      .clk       (CLK),
      .rst       (RST),
      .set_i     (set_vec[i]),
      .set_var_i (lat_is_var),
      .set_cnt_i (lat_ext),
      .wb_hit_i  (bus.wb_valid & wb_oh[i]),
      .kill_hit_i(bus.kill_valid & kill_oh[i]),
      .pend_o    (pend_vec[i]),
      .var_o     (var_vec[i]),
      .clr_now_o (clr_vec[i])
    );
  end

  assign hz_pend = pend_vec & ~(clr_vec & {NREGS{WB_BYPASS}});

  assign raw = (bus.issue_rs1_used & |(hz_pend & rs1_oh)) |
               (bus.issue_rs2_used & |(hz_pend & rs2_oh));
  assign waw = wen_nz & |(hz_pend & rd_oh);

  assign busy_w   = |pend_vec;
  assign var_busy = |(pend_vec & var_vec);

  assign issue_ready_w = (state_q == RUN) & ~bus.redirect & ~bus.intr_req &
                         ~bus.fence_req & ~raw & ~waw;
  assign fire          = bus.issue_valid & issue_ready_w;

  // Interrupts are only taken once no variable-latency result can still land.
  assign intr_ack_w = bus.intr_req & ~var_busy &
                      (((state_q == RUN) & ~bus.redirect) | (state_q == DRAIN_I));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      fence_ack_q <= 1'b0;
    end else begin
      fence_ack_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (!bus.redirect) begin
            if (bus.intr_req) begin
              if (var_busy) begin
                state_q <= DRAIN_I;
              end
            end else if (bus.fence_req) begin
              state_q <= DRAIN_F;
            end
          end
        end
        DRAIN_I: begin
          if (!bus.intr_req || !var_busy) begin
            state_q <= RUN;
          end
        end
        DRAIN_F: begin
          if (!busy_w) begin
            state_q     <= ACK_F;
            fence_ack_q <= 1'b1;
          end
        end
        ACK_F: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign bus.issue_ready = issue_ready_w;
  assign bus.fence_ack   = fence_ack_q;
  assign bus.intr_ack    = intr_ack_w;
  assign bus.flush_front = bus.redirect | intr_ack_w;
  assign bus.stall_front = (bus.issue_valid & ~issue_ready_w) | (state_q != RUN);
  assign bus.busy        = busy_w;

  lat_legal: assert property (@(posedge CLK) disable iff (RST)
    bus.issue_valid |-> (bus.issue_lat <= LAT_W'(MAX_LAT)));

endmodule
